// File: rtl/param_register_file.sv
// Parameterised register file with two registered read ports, write-first bypass,
// a per-register busy scoreboard and a registered out-of-range address flag.
module param_register_file #(
    parameter int DATA_W   = 20,
    parameter int ADDR_W   = 4,
    parameter int NUM_REGS = 8
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              RW,
    input  logic [ADDR_W-1:0] Dest,
    input  logic [DATA_W-1:0] Data,
    input  logic [ADDR_W-1:0] Reg1,
    input  logic [ADDR_W-1:0] Reg2,
    input  logic              Issue,
    input  logic [ADDR_W-1:0] Issue_Dest,
    output logic [DATA_W-1:0] out_reg1,
    output logic [DATA_W-1:0] out_reg2,
    output logic              busy1,
    output logic              busy2,
    output logic              addr_err
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_W:0] NREGS = NUM_REGS[ADDR_W:0];

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_nxt;

    logic dest_ok, iss_ok, rd1_ok, rd2_ok;
    logic wr_en, iss_en;
    logic [IDX_W-1:0] wr_idx, iss_idx, rd1_idx, rd2_idx;

    assign dest_ok = ({1'b0, Dest}       < NREGS);
    assign iss_ok  = ({1'b0, Issue_Dest} < NREGS);
    assign rd1_ok  = ({1'b0, Reg1}       < NREGS);
    assign rd2_ok  = ({1'b0, Reg2}       < NREGS);

    assign wr_en  = RW && dest_ok;
    assign iss_en = Issue && iss_ok;

    assign wr_idx  = Dest[IDX_W-1:0];
    assign iss_idx = Issue_Dest[IDX_W-1:0];
    assign rd1_idx = Reg1[IDX_W-1:0];
    assign rd2_idx = Reg2[IDX_W-1:0];

    // Issue is applied after the write-clear so a same-cycle issue keeps the bit set.
    always_comb begin
        busy_nxt = busy;
        if (wr_en)
            busy_nxt[wr_idx] = 1'b0;
        if (iss_en)
            busy_nxt[iss_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
            busy     <= '0;
            out_reg1 <= '0;
            out_reg2 <= '0;
            busy1    <= 1'b0;
            busy2    <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            if (wr_en)
                regs[wr_idx] <= Data;
            busy <= busy_nxt;

            // Read stage: write-first bypass, zero for out-of-range addresses.
            if (!rd1_ok)
                out_reg1 <= '0;
            else if (wr_en && (Dest == Reg1))
                out_reg1 <= Data;
            else
                out_reg1 <= regs[rd1_idx];

            if (!rd2_ok)
                out_reg2 <= '0;
            else if (wr_en && (Dest == Reg2))
                out_reg2 <= Data;
            else
                out_reg2 <= regs[rd2_idx];

            busy1 <= rd1_ok ? busy_nxt[rd1_idx] : 1'b0;
            busy2 <= rd2_ok ? busy_nxt[rd2_idx] : 1'b0;

            addr_err <= !rd1_ok || !rd2_ok || (RW && !dest_ok) || (Issue && !iss_ok);
        end
    end

endmodule
